// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Shares one memory request/response port between the L1 instruction cache
//   (client 0) and the L1 data cache (client 1). Round-robin arbitration. Only
//   one transaction is in flight at a time. The response is routed back to
//   the client that owns the transaction.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   icache_*            client 0 request/response channel (server side)
//   dcache_*            client 1 request/response channel (server side)
//   mem_*               shared memory channel (client side)
//   busy                high whenever the FSM is not IDLE
//   grant               owner of the current transaction (0=icache, 1=dcache)
//   err_timeout         sticky: response watchdog saturated in WAIT_RESP
//   err_stray           sticky: mem_resp_valid seen outside WAIT_RESP
module l1_mem_arbiter #(
  parameter int unsigned TIMEOUT_BITS = 10,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ID_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  // client 0: instruction cache
  input  logic              icache_req_valid,
  output logic              icache_req_ready,
  input  logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_req_we,
  input  logic [ID_W-1:0]   icache_req_id,
  input  logic [DATA_W-1:0] icache_req_data,
  output logic              icache_resp_valid,
  input  logic              icache_resp_ready,
  output logic [DATA_W-1:0] icache_resp_data,
  // client 1: data cache
  input  logic              dcache_req_valid,
  output logic              dcache_req_ready,
  input  logic [ADDR_W-1:0] dcache_req_addr,
  input  logic              dcache_req_we,
  input  logic [ID_W-1:0]   dcache_req_id,
  input  logic [DATA_W-1:0] dcache_req_data,
  output logic              dcache_resp_valid,
  input  logic              dcache_resp_ready,
  output logic [DATA_W-1:0] dcache_resp_data,
  // shared memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [ID_W-1:0]   mem_req_id,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  // status
  output logic              busy,
  output logic              grant,
  output logic              err_timeout,
  output logic              err_stray
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  logic [1:0]              state;
  logic                    rr_last;
  logic [TIMEOUT_BITS-1:0] watchdog;
  logic [TIMEOUT_BITS-1:0] watchdog_next;

  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;
  logic [ID_W-1:0]   hold_id;
  logic [DATA_W-1:0] hold_data;

  logic winner;
  logic any_req;
  logic in_idle;
  logic in_wait;
  logic accept;

  // Ties go to the client that did not win last time.
  always_comb begin
    any_req = icache_req_valid | dcache_req_valid;
    if (icache_req_valid && dcache_req_valid) begin
      winner = ~rr_last;
    end else begin
      winner = dcache_req_valid;
    end
  end

  // The !rst terms keep every client handshake quiet while reset is held,
  // even if the state register has not yet returned to IDLE.
  assign in_idle = (state == IDLE) && !rst;
  assign in_wait = (state == WAIT_RESP) && !rst;
  assign accept  = in_idle && any_req;

  assign icache_req_ready = in_idle && icache_req_valid && !winner;
  assign dcache_req_ready = in_idle && dcache_req_valid && winner;

  // Response path is purely combinational: no added latency.
  assign icache_resp_valid = in_wait && !grant && mem_resp_valid;
  assign dcache_resp_valid = in_wait &&  grant && mem_resp_valid;
  assign icache_resp_data  = mem_resp_data;
  assign dcache_resp_data  = mem_resp_data;

  // Outside WAIT_RESP any response is drained and flagged as stray.
  assign mem_resp_ready = (state == WAIT_RESP) ?
                          (grant ? dcache_resp_ready : icache_resp_ready) : 1'b1;

  assign mem_req_valid = (state == ISSUE) && !rst;
  assign mem_req_addr  = hold_addr;
  assign mem_req_we    = hold_we;
  assign mem_req_id    = hold_id;
  assign mem_req_data  = hold_data;

  assign busy = (state != IDLE);

  assign watchdog_next = (watchdog == '1) ? watchdog : watchdog + TIMEOUT_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= 1'b0;
      grant       <= 1'b0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= winner;
            rr_last <= winner;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            watchdog <= '0;
            state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          watchdog <= watchdog_next;
          if (watchdog_next == '1) begin
            err_timeout <= 1'b1;
          end
          if (mem_resp_valid && mem_resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if ((state != WAIT_RESP) && mem_resp_valid) begin
        err_stray <= 1'b1;
      end
    end
  end

  // Holding registers carry no reset: they are only observed in ISSUE,
  // which is always preceded by a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_addr <= winner ? dcache_req_addr : icache_req_addr;
      hold_we   <= winner ? dcache_req_we   : icache_req_we;
      hold_id   <= winner ? dcache_req_id   : icache_req_id;
      hold_data <= winner ? dcache_req_data : icache_req_data;
    end
  end

endmodule
